// File: rtl/key_event_encoder_pkg.sv
// rtl/key_event_encoder_pkg.sv - key indices and FSM code constants shared with the range-hood mode FSM
package key_event_encoder_pkg;

    localparam int NUM_KEYS_DEF = 5;

    localparam int KEY_MENU  = 4;
    localparam int KEY_L1    = 3;
    localparam int KEY_L2    = 2;
    localparam int KEY_HURR  = 1;
    localparam int KEY_CLEAN = 0;

    // {enable, one-hot key} codes as seen by the mode FSM
    localparam logic [5:0] CODE_MENU  = 6'b110000;
    localparam logic [5:0] CODE_L1    = 6'b101000;
    localparam logic [5:0] CODE_L2    = 6'b100100;
    localparam logic [5:0] CODE_HURR  = 6'b100010;
    localparam logic [5:0] CODE_CLEAN = 6'b100001;

endpackage

// File: rtl/key_event_encoder_debounce.sv
// rtl/key_event_encoder_debounce.sv - per-key 2-FF synchroniser, debounce counter and press-edge flag
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 29
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_raw_i,
    output logic deb_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle of agreement restarts the count, so only an uninterrupted run flips the level.
    always_comb begin
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        press_d = 1'b0;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            deb_d   = sync2_q;
            press_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounced level resets high so a key held through reset must be released first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o   = deb_q;
    assign press_o = press_q;

endmodule

// File: rtl/key_event_encoder.sv
// rtl/key_event_encoder.sv - conditions raw buttons into one-cycle key codes, long-press and conflict pulses
module key_event_encoder
    import key_event_encoder_pkg::*;
#(
    parameter int NUM_KEYS          = NUM_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 300_000_000,
    parameter int CNT_W             = 29
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic [NUM_KEYS:0]   key_code,
    output logic                key_valid,
    output logic [NUM_KEYS-1:0] long_press,
    output logic                conflict
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_PRESS_CYCLES);

    logic [NUM_KEYS-1:0] deb, press;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk_i    (clk),
            .rst_i    (rst),
            .key_raw_i(key_raw[k]),
            .deb_o    (deb[k]),
            .press_o  (press[k])
        );
    end

    logic [NUM_KEYS-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    lcnt_q, lcnt_d;
    logic [NUM_KEYS-1:0] pulse_q, pulse_d;
    logic [NUM_KEYS-1:0] long_q, long_d;
    logic [NUM_KEYS:0]   code_q, code_d;
    logic                valid_q, valid_d;
    logic                conf_q, conf_d;

    logic single_ok, acc_held;

    assign single_ok = $onehot(press) && ((deb & ~press) == '0);
    assign acc_held  = |(acc_q & deb);

    always_comb begin
        pulse_d = '0;
        long_d  = '0;
        valid_d = 1'b0;
        conf_d  = 1'b0;
        acc_d   = acc_q;
        lcnt_d  = lcnt_q;
        if (!enable) begin
            acc_d  = '0;
            lcnt_d = '0;
        end else begin
            if ((acc_q != '0) && !acc_held) begin
                acc_d  = '0;
                lcnt_d = '0;
            end else if (acc_held) begin
                if (lcnt_q == LONG_LAST) begin
                    long_d = acc_q;
                end
                // Stop one past the pulse point so the long press fires only once.
                if (lcnt_q != LONG_SAT) begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            if (press != '0) begin
                if (single_ok) begin
                    pulse_d = press;
                    valid_d = 1'b1;
                    acc_d   = press;
                    lcnt_d  = '0;
                end else begin
                    conf_d = 1'b1;
                end
            end
        end
        code_d = {enable, pulse_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            lcnt_q  <= '0;
            pulse_q <= '0;
            long_q  <= '0;
            valid_q <= 1'b0;
            conf_q  <= 1'b0;
            code_q  <= {enable, {NUM_KEYS{1'b0}}};
        end else begin
            acc_q   <= acc_d;
            lcnt_q  <= lcnt_d;
            pulse_q <= pulse_d;
            long_q  <= long_d;
            valid_q <= valid_d;
            conf_q  <= conf_d;
            code_q  <= code_d;
        end
    end

    assign key_pulse  = pulse_q;
    assign key_code   = code_q;
    assign key_valid  = valid_q;
    assign long_press = long_q;
    assign conflict   = conf_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// tb/tb_key_event_encoder.sv - scoreboard bench for key_event_encoder with a behavioural key model
module tb_key_event_encoder;
    import key_event_encoder_pkg::*;

    localparam int D = 4;
    localparam int L = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [4:0] key_raw;
    logic [4:0] key_pulse;
    logic [5:0] key_code;
    logic       key_valid;
    logic [4:0] long_press;
    logic       conflict;

    key_event_encoder #(
        .NUM_KEYS         (5),
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .CNT_W            (29)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .key_raw   (key_raw),
        .key_pulse (key_pulse),
        .key_code  (key_code),
        .key_valid (key_valid),
        .long_press(long_press),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [4:0] pulse;
        logic [4:0] lng;
        logic       conf;
    } exp_t;
    exp_t exp_q[$];

    // Model: a key's level flips once the synchronised input has shown the
    // opposite value for the last D sampled edges since reset.
    logic [4:0] m_hist[$];
    logic [4:0] m_deb   = 5'b11111;
    logic [4:0] m_press = 5'b0;
    logic [5:0] m_code  = 6'b100000;
    int         m_n = 0;
    int         m_acc = -1;
    int         m_acc_edge = 0;

    function automatic logic [4:0] sync_at(input int n);
        if (n >= 3) return m_hist[n-3];
        return 5'b0;
    endfunction

    always @(posedge clk) begin
        exp_t       e;
        int         npress, nother;
        logic [4:0] newp, s;
        logic       all_opp;
        cyc++;
        if (rst) begin
            m_n = 0;
            m_hist.delete();
            m_deb = 5'b11111;
            m_press = 5'b0;
            m_acc = -1;
            m_code = {enable, 5'b0};
        end else begin
            m_n++;
            m_hist.push_back(key_raw);
            e.cyc = cyc; e.pulse = 5'b0; e.lng = 5'b0; e.conf = 1'b0;
            npress = $countones(m_press);
            nother = $countones(m_deb & ~m_press);
            if (enable) begin
                if (m_acc >= 0 && !m_deb[m_acc]) m_acc = -1;
                else if (m_acc >= 0 && (m_n - m_acc_edge) == L) e.lng[m_acc] = 1'b1;
                if (npress == 1 && nother == 0) begin
                    e.pulse = m_press;
                    for (int k = 0; k < 5; k++) if (m_press[k]) m_acc = k;
                    m_acc_edge = m_n;
                end else if (npress > 0) begin
                    e.conf = 1'b1;
                end
            end else begin
                m_acc = -1;
            end
            m_code = {enable, e.pulse};
            if (e.pulse != 0 || e.lng != 0 || e.conf) exp_q.push_back(e);
            newp = 5'b0;
            for (int k = 0; k < 5; k++) begin
                if (m_n >= D) begin
                    all_opp = 1'b1;
                    for (int j = 0; j < D; j++) begin
                        s = sync_at(m_n - j);
                        if (s[k] == m_deb[k]) all_opp = 1'b0;
                    end
                    if (all_opp) begin
                        m_deb[k] = ~m_deb[k];
                        newp[k] = m_deb[k];
                    end
                end
            end
            m_press = newp;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (key_code !== m_code) begin
            errors++;
            $display("FAIL key_code cyc=%0d actual=%b required=%b", cyc, key_code, m_code);
        end
        if (key_valid || conflict || key_pulse != 0 || long_press != 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d actual pulse=%b valid=%b long=%b conf=%b required none",
                         cyc, key_pulse, key_valid, long_press, conflict);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.pulse !== key_pulse || (e.pulse != 0) !== key_valid ||
                    e.lng !== long_press || e.conf !== conflict) begin
                    errors++;
                    $display("FAIL event cyc=%0d actual pulse=%b valid=%b long=%b conf=%b required cyc=%0d pulse=%b long=%b conf=%b",
                             cyc, key_pulse, key_valid, long_press, conflict, e.cyc, e.pulse, e.lng, e.conf);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_event cyc=%0d actual none required cyc=%0d pulse=%b long=%b conf=%b",
                     cyc, e.cyc, e.pulse, e.lng, e.conf);
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    int         nv, nl, nc, fv, fl;
    logic [4:0] pv, lv;
    logic [5:0] cv;

    task automatic watch(input int n);
        nv = 0; nl = 0; nc = 0; fv = -1; fl = -1; pv = 5'b0; lv = 5'b0; cv = 6'b0;
        repeat (n) begin
            @(negedge clk);
            if (key_valid) begin
                nv++;
                if (fv < 0) begin fv = cyc; pv = key_pulse; cv = key_code; end
            end
            if (long_press != 0) begin
                nl++;
                if (fl < 0) begin fl = cyc; lv = long_press; end
            end
            if (conflict) nc++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int c0;

    initial begin
        rst = 1'b1; enable = 1'b1; key_raw = 5'b0;
        idle(3);
        chk("reset_code", key_code, 6'b100000);
        chk("reset_pulse", key_pulse, 0);
        rst = 1'b0;
        idle(10);

        c0 = cyc; key_raw[KEY_MENU] = 1'b1;
        watch(12);
        chk("s1_latency", fv, c0 + 7);
        chk("s1_pulse", pv, 5'b10000);
        chk("s1_code", cv, CODE_MENU);
        chk("s1_count", nv, 1);
        key_raw = 5'b0; idle(12);

        key_raw[KEY_L1] = 1'b1; idle(1);
        key_raw[KEY_L1] = 1'b0; idle(1);
        key_raw[KEY_L1] = 1'b1; idle(1);
        key_raw[KEY_L1] = 1'b0; idle(1);
        c0 = cyc; key_raw[KEY_L1] = 1'b1;
        watch(12);
        chk("s2_latency", fv, c0 + 7);
        chk("s2_pulse", pv, 5'b01000);
        chk("s2_count", nv, 1);
        key_raw = 5'b0; idle(12);

        key_raw = 5'b00110;
        watch(12);
        chk("s3_conflict", nc, 1);
        chk("s3_no_valid", nv, 0);
        key_raw = 5'b01100;
        watch(12);
        chk("s3_conflict_held", nc, 1);
        chk("s3_no_valid_held", nv, 0);
        key_raw = 5'b0; idle(12);

        c0 = cyc; key_raw[KEY_HURR] = 1'b1;
        watch(30);
        chk("s4_latency", fv, c0 + 7);
        chk("s4_long_time", fl, c0 + 7 + L);
        chk("s4_long_val", lv, 5'b00010);
        chk("s4_long_once", nl, 1);
        key_raw = 5'b0; idle(12);
        key_raw[KEY_HURR] = 1'b1;
        watch(10);
        chk("s4_short_valid", nv, 1);
        key_raw = 5'b0;
        watch(30);
        chk("s4_short_no_long", nl, 0);
        idle(5);

        enable = 1'b0; key_raw[KEY_CLEAN] = 1'b1;
        watch(12);
        chk("s5_disabled_events", nv + nl + nc, 0);
        chk("s5_disabled_code", key_code, 6'b000000);
        enable = 1'b1;
        watch(14);
        chk("s5_no_replay", nv, 0);
        key_raw = 5'b0; idle(12);
        c0 = cyc; key_raw[KEY_CLEAN] = 1'b1;
        watch(9);
        chk("s5_repress_latency", fv, c0 + 7);
        chk("s5_repress_pulse", pv, 5'b00001);
        key_raw = 5'b0; idle(12);

        key_raw[KEY_HURR] = 1'b1;
        watch(12);
        chk("s6_first_valid", nv, 1);
        rst = 1'b1; idle(2); rst = 1'b0;
        watch(40);
        chk("s6_held_no_valid", nv, 0);
        chk("s6_held_no_long", nl, 0);
        key_raw = 5'b0; idle(12);
        c0 = cyc; key_raw[KEY_HURR] = 1'b1;
        watch(9);
        chk("s6_repress_latency", fv, c0 + 7);
        key_raw = 5'b0; idle(12);

        for (int it = 0; it < 140; it++) begin
            int sel, k;
            sel = $urandom_range(0, 9);
            k = $urandom_range(0, 4);
            if (sel <= 4) begin
                key_raw = 5'b0; key_raw[k] = 1'b1;
                idle($urandom_range(1, 35));
                key_raw = 5'b0;
                idle($urandom_range(0, 14));
            end else if (sel == 5) begin
                key_raw = 5'($urandom_range(1, 31));
                idle($urandom_range(2, 20));
                key_raw = 5'b0;
                idle($urandom_range(0, 10));
            end else if (sel == 6) begin
                repeat (8) begin
                    key_raw = 5'b0; key_raw[k] = 1'($urandom_range(0, 1));
                    idle(1);
                end
            end else if (sel == 7) begin
                enable = ~enable;
                idle($urandom_range(1, 10));
            end else if (sel == 8 && $urandom_range(0, 3) == 0) begin
                rst = 1'b1; idle($urandom_range(1, 2)); rst = 1'b0;
            end else begin
                idle($urandom_range(1, 8));
            end
        end

        key_raw = 5'b0; enable = 1'b1;
        idle(50);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
